// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types for the instruction fetch stage.
// Width constants match the decoder's instruction word.
package ifetch_pkg;

  localparam int IW  = 16;
  localparam int PCW = 8;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  instr;
  } entry_t;

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory and decoder-side signals of the
// fetch stage; master is the fetch unit, slave is its environment.
interface ifetch_if
  import ifetch_pkg::*;
#(
  parameter int AW = 8
);

  logic          imreq;
  logic [AW-1:0] imadr;
  logic          imack;
  logic [IW-1:0] imdat;
  logic [IW-1:0] ins;
  logic [AW-1:0] ins_pc;
  logic          ins_v;
  logic          ins_rdy;
  logic          halt;
  logic          redir;
  logic [AW-1:0] redir_pc;
  logic          running;

  modport master (
    output imreq, imadr, ins, ins_pc, ins_v, running,
    input  imack, imdat, ins_rdy, halt, redir, redir_pc
  );

  modport slave (
    input  imreq, imadr, ins, ins_pc, ins_v, running,
    output imack, imdat, ins_rdy, halt, redir, redir_pc
  );

endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: first-word-fall-through buffer with registered
// head storage; flush wins over push and pop.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rstd,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CMAX = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CMAX);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rp];

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, do_push}
                 - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= din;
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch PC, one outstanding imem request and a small
// instruction buffer feeding the decoder.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 2
) (
  input logic      clk,
  input logic      rstd,
  ifetch_if.master bus
);

  localparam int W = AW + IW;

  state_t        state;
  logic [AW-1:0] fpc;
  logic [AW-1:0] adr;
  logic          req;
  logic          discard;
  logic          ack;
  logic          pop;
  logic          hpop;
  logic          flush;
  logic          push;
  logic          issue;
  logic          full;
  logic          empty;
  logic [W-1:0]  head;

  assign ack   = req && bus.imack;
  assign pop   = bus.ins_v && bus.ins_rdy;
  assign hpop  = pop && bus.halt;
  assign flush = bus.redir || hpop;
  assign push  = ack && !discard && !flush;
  assign issue = (state == RUN) && !req
              && !full && !flush;

  // adr is latched at issue so imadr stays put
  // even when a redirect moves fpc mid-request
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state   <= RUN;
      fpc     <= '0;
      adr     <= '0;
      req     <= 1'b0;
      discard <= 1'b0;
    end else begin
      if (bus.redir)  state <= RUN;
      else if (hpop)  state <= HALTED;

      if (bus.redir)  fpc <= bus.redir_pc;
      else if (push)  fpc <= fpc + 1'b1;

      if (issue) adr <= fpc;

      if (ack)        req <= 1'b0;
      else if (issue) req <= 1'b1;

      if (flush && req && !bus.imack)
        discard <= 1'b1;
      else if (ack)
        discard <= 1'b0;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rstd  (rstd),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({fpc, bus.imdat}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign bus.imreq   = req;
  assign bus.imadr   = adr;
  assign bus.ins     = head[IW-1:0];
  assign bus.ins_pc  = head[W-1:IW];
  assign bus.ins_v   = !empty;
  assign bus.running = (state == RUN);

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios for the fetch stage against a
// memory model with configurable latency (imdat = 16'h1000 + adr).
module tb_ifetch_unit;
  import ifetch_pkg::*;

  logic clk = 1'b0;
  logic rstd = 1'b0;
  always #5 clk = ~clk;

  ifetch_if #(.AW(8)) bus();

  ifetch_unit #(.AW(8), .DEPTH(2)) dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int lat = 1;
  int cnt = 0;
  int stab_err = 0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic [7:0] prev_adr = '0;
  logic [7:0] adr_q[$];
  entry_t got_q[$];

  // memory: answers lat cycles after imreq rises
  always @(posedge clk) begin
    #2;
    if (!rstd || !bus.imreq) begin
      bus.imack = 1'b0;
      cnt = 0;
    end else if (cnt + 1 >= lat) begin
      bus.imack = 1'b1;
      bus.imdat = 16'h1000 + {8'h00, bus.imadr};
      cnt = 0;
    end else begin
      bus.imack = 1'b0;
      cnt++;
    end
  end

  // monitor: issued addresses, delivered entries, request stability
  always @(negedge clk) begin
    if (!rstd) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_req && !prev_ack
          && (!bus.imreq || bus.imadr != prev_adr))
        stab_err++;
      if (bus.imreq && (!prev_req || prev_ack))
        adr_q.push_back(bus.imadr);
      if (bus.ins_v && bus.ins_rdy && !bus.redir)
        got_q.push_back({bus.ins_pc, bus.ins});
      prev_req = bus.imreq;
      prev_ack = bus.imack;
      prev_adr = bus.imadr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstd = 1'b0;
    bus.ins_rdy = 1'b0;
    bus.halt = 1'b0;
    bus.redir = 1'b0;
    bus.redir_pc = '0;
    lat = 1;
    cycles(2);
    rstd = 1'b1;
    adr_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rstd = 1'b0;
    bus.ins_rdy = 1'b0;
    bus.halt = 1'b0;
    bus.redir = 1'b0;
    bus.redir_pc = '0;
    cycles(1);
    tests++;
    if (bus.imreq !== 1'b0) begin
      fails++;
      $display("FAIL reset_imreq got=%0b exp=0", bus.imreq);
    end
    tests++;
    if (bus.ins_v !== 1'b0) begin
      fails++;
      $display("FAIL reset_ins_v got=%0b exp=0", bus.ins_v);
    end
    tests++;
    if (bus.running !== 1'b1) begin
      fails++;
      $display("FAIL reset_running got=%0b exp=1", bus.running);
    end
    tests++;
    if (bus.ins !== 16'h0 || bus.ins_pc !== 8'h0) begin
      fails++;
      $display("FAIL reset_head got=%h/%h exp=0000/00",
               bus.ins, bus.ins_pc);
    end
  endtask

  task automatic test_stream();
    logic [7:0] a;
    entry_t e;
    entry_t g;
    do_reset();
    bus.ins_rdy = 1'b1;
    cycles(14);
    for (int i = 0; i < 4; i++) begin
      a = (i < adr_q.size()) ? adr_q[i] : 8'hEE;
      tests++;
      if (a !== 8'(i)) begin
        fails++;
        $display("FAIL stream_adr%0d got=%h exp=%h", i, a, 8'(i));
      end
    end
    for (int i = 0; i < 3; i++) begin
      e = {8'(i), 16'h1000 + 16'(i)};
      g = (i < got_q.size()) ? got_q[i] : '0;
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL stream_ins%0d got=%h/%h exp=%h/%h",
                 i, g.pc, g.instr, e.pc, e.instr);
      end
    end
    tests++;
    if (stab_err !== 0) begin
      fails++;
      $display("FAIL stream_req_stable got=%0d exp=0", stab_err);
    end
  endtask

  task automatic test_backpressure();
    entry_t e;
    entry_t g;
    do_reset();
    cycles(10);
    tests++;
    if (bus.ins_v !== 1'b1 || bus.ins !== 16'h1000
        || bus.ins_pc !== 8'h00) begin
      fails++;
      $display("FAIL bp_head got=%0b/%h/%h exp=1/1000/00",
               bus.ins_v, bus.ins, bus.ins_pc);
    end
    tests++;
    if (bus.imreq !== 1'b0) begin
      fails++;
      $display("FAIL bp_imreq got=%0b exp=0", bus.imreq);
    end
    tests++;
    if (adr_q.size() !== 2) begin
      fails++;
      $display("FAIL bp_issued got=%0d exp=2", adr_q.size());
    end
    bus.ins_rdy = 1'b1;
    cycles(12);
    for (int i = 0; i < 4; i++) begin
      e = {8'(i), 16'h1000 + 16'(i)};
      g = (i < got_q.size()) ? got_q[i] : '0;
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL bp_ins%0d got=%h/%h exp=%h/%h",
                 i, g.pc, g.instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_halt();
    bit done = 1'b0;
    entry_t g;
    do_reset();
    lat = 3;
    for (int i = 0; i < 80 && !done; i++) begin
      cycles(1);
      if (!bus.running) begin
        done = 1'b1;
      end else begin
        bus.halt = bus.ins_v && (bus.ins_pc == 8'h02);
        bus.ins_rdy = !(bus.halt && !bus.imreq);
      end
    end
    bus.halt = 1'b0;
    bus.ins_rdy = 1'b1;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL halt_timeout running=%0b exp=0", bus.running);
    end
    tests++;
    if (bus.imreq !== 1'b1) begin
      fails++;
      $display("FAIL halt_req_held got=%0b exp=1", bus.imreq);
    end
    cycles(10);
    tests++;
    if (bus.imreq !== 1'b0 || bus.ins_v !== 1'b0
        || bus.running !== 1'b0) begin
      fails++;
      $display("FAIL halt_idle got=%0b/%0b/%0b exp=0/0/0",
               bus.imreq, bus.ins_v, bus.running);
    end
    tests++;
    if (adr_q.size() !== 4) begin
      fails++;
      $display("FAIL halt_issued got=%0d exp=4", adr_q.size());
    end
    g = (got_q.size() > 2) ? got_q[2] : '0;
    tests++;
    if (got_q.size() !== 3 || g.pc !== 8'h02) begin
      fails++;
      $display("FAIL halt_delivered got=%0d/%h exp=3/02",
               got_q.size(), g.pc);
    end
    tests++;
    if (stab_err !== 0) begin
      fails++;
      $display("FAIL halt_req_stable got=%0d exp=0", stab_err);
    end
  endtask

  task automatic test_redir_from_halt();
    logic [7:0] a;
    entry_t g;
    lat = 1;
    bus.ins_rdy = 1'b0;
    bus.redir_pc = 8'h40;
    bus.redir = 1'b1;
    cycles(1);
    bus.redir = 1'b0;
    tests++;
    if (bus.running !== 1'b1 || bus.imreq !== 1'b0) begin
      fails++;
      $display("FAIL redir_run got=%0b/%0b exp=1/0",
               bus.running, bus.imreq);
    end
    adr_q.delete();
    got_q.delete();
    bus.ins_rdy = 1'b1;
    cycles(8);
    a = (adr_q.size() > 0) ? adr_q[0] : 8'hEE;
    tests++;
    if (a !== 8'h40) begin
      fails++;
      $display("FAIL redir_adr got=%h exp=40", a);
    end
    g = (got_q.size() > 0) ? got_q[0] : '0;
    tests++;
    if (g.pc !== 8'h40 || g.instr !== 16'h1040) begin
      fails++;
      $display("FAIL redir_ins got=%h/%h exp=40/1040", g.pc, g.instr);
    end
  endtask

  task automatic test_redir_on_ack();
    bit found = 1'b0;
    int n5 = 0;
    entry_t g4;
    entry_t g5;
    do_reset();
    bus.ins_rdy = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #3;
      if (bus.imack && bus.imadr == 8'h05) found = 1'b1;
    end
    bus.redir_pc = 8'h10;
    bus.redir = 1'b1;
    cycles(1);
    bus.redir = 1'b0;
    cycles(10);
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL roa_timeout got=0 exp=1");
    end
    foreach (got_q[i]) if (got_q[i].pc == 8'h05) n5++;
    tests++;
    if (n5 !== 0) begin
      fails++;
      $display("FAIL roa_dropped got=%0d exp=0", n5);
    end
    g4 = (got_q.size() > 4) ? got_q[4] : '0;
    g5 = (got_q.size() > 5) ? got_q[5] : '0;
    tests++;
    if (g4.pc !== 8'h04 || g5.pc !== 8'h10
        || g5.instr !== 16'h1010) begin
      fails++;
      $display("FAIL roa_next got=%h,%h/%h exp=04,10/1010",
               g4.pc, g5.pc, g5.instr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ep [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    entry_t e;
    entry_t g;
    do_reset();
    bus.redir_pc = 8'hFE;
    bus.redir = 1'b1;
    cycles(1);
    bus.redir = 1'b0;
    adr_q.delete();
    got_q.delete();
    bus.ins_rdy = 1'b1;
    cycles(14);
    for (int i = 0; i < 4; i++) begin
      e = {ep[i], 8'h10, ep[i]};
      g = (i < got_q.size()) ? got_q[i] : '0;
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL wrap%0d got=%h/%h exp=%h/%h",
                 i, g.pc, g.instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    logic [7:0] a;
    entry_t g;
    do_reset();
    lat = 3;
    for (int i = 0; i < 40 && !found; i++) begin
      cycles(1);
      if (bus.imreq && bus.ins_v) found = 1'b1;
    end
    #2;
    rstd = 1'b0;
    #1;
    tests++;
    if (!found || bus.imreq !== 1'b0 || bus.ins_v !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got=%0b/%0b/%0b exp=1/0/0",
               found, bus.imreq, bus.ins_v);
    end
    cycles(1);
    rstd = 1'b1;
    lat = 1;
    adr_q.delete();
    got_q.delete();
    bus.ins_rdy = 1'b1;
    cycles(8);
    a = (adr_q.size() > 0) ? adr_q[0] : 8'hEE;
    g = (got_q.size() > 0) ? got_q[0] : '1;
    tests++;
    if (a !== 8'h00 || g.pc !== 8'h00 || g.instr !== 16'h1000) begin
      fails++;
      $display("FAIL mid_resume got=%h,%h/%h exp=00,00/1000",
               a, g.pc, g.instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_halt();
    test_redir_from_halt();
    test_redir_on_ack();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
